// File: rtl/dev_bridge_if.sv
// CPU-side data port and peripheral register bus of dev_bridge, bundled with the IRQ lines.
// master = bridge view, slave = CPU/device environment view.
interface dev_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_ready;
    logic        cpu_err;
    logic [31:0] dev_addr;
    logic [31:0] dev_wd;
    logic        dev0_we;
    logic        dev1_we;
    logic [31:0] dev0_rd;
    logic [31:0] dev1_rd;
    logic        dev0_irq;
    logic        dev1_irq;
    logic [3:0]  ext_irq;
    logic [5:0]  HWInt;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_ready, cpu_err,
        output dev_addr, dev_wd, dev0_we, dev1_we,
        input  dev0_rd, dev1_rd, dev0_irq, dev1_irq, ext_irq,
        output HWInt
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_ready, cpu_err,
        input  dev_addr, dev_wd, dev0_we, dev1_we,
        output dev0_rd, dev1_rd, dev0_irq, dev1_irq, ext_irq,
        input  HWInt
    );
endinterface

// File: rtl/dev_bridge.sv
// CPU-to-peripheral register bus bridge with two decoded device windows and HWInt collection.
// Optional macro BRIDGE_IRQ_SYNC_EN: 2-flop synchronizer on ext_irq ahead of the HWInt register.
module dev_bridge #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter logic [31:0] DEV_SPAN  = 32'd16
) (
    input  logic         clk,
    input  logic         reset,
    dev_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        sel0_q, sel0_d;
    logic        sel1_q, sel1_d;
    logic [31:0] dev_addr_q, dev_addr_d;
    logic [31:0] dev_wd_q, dev_wd_d;
    logic [31:0] cpu_rd_q, cpu_rd_d;
    logic [5:0]  hwint_q, hwint_d;

    logic [31:0] off0, off1;
    logic        hit0, hit1, misaligned;

    // Unsigned wrap-around makes a single compare cover both window edges; dev0 wins on overlap.
    always_comb begin
        off0       = bus.cpu_addr - DEV0_BASE;
        off1       = bus.cpu_addr - DEV1_BASE;
        hit0       = (off0 < DEV_SPAN);
        hit1       = (off1 < DEV_SPAN) && !hit0;
        misaligned = (bus.cpu_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        sel0_d     = sel0_q;
        sel1_d     = sel1_q;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        cpu_rd_d   = cpu_rd_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    we_d       = bus.cpu_we;
                    sel0_d     = hit0;
                    sel1_d     = hit1;
                    dev_addr_d = bus.cpu_addr;
                    dev_wd_d   = bus.cpu_wd;
                    // Cleared on acceptance so an ERR response reads back as 0.
                    cpu_rd_d   = 32'd0;
                    state_d    = (misaligned || !(hit0 || hit1)) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q)        cpu_rd_d = 32'd0;
                else if (sel0_q) cpu_rd_d = bus.dev0_rd;
                else             cpu_rd_d = bus.dev1_rd;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            sel0_q     <= 1'b0;
            sel1_q     <= 1'b0;
            dev_addr_q <= 32'd0;
            dev_wd_q   <= 32'd0;
            cpu_rd_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
            cpu_rd_q   <= cpu_rd_d;
        end
    end

`ifdef BRIDGE_IRQ_SYNC_EN
    logic [3:0] ext_s1_q, ext_s1_d;
    logic [3:0] ext_s2_q, ext_s2_d;

    always_comb begin
        ext_s1_d = bus.ext_irq;
        ext_s2_d = ext_s1_q;
        hwint_d  = {ext_s2_q, bus.dev1_irq, bus.dev0_irq};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_s1_q <= 4'd0;
            ext_s2_q <= 4'd0;
        end else begin
            ext_s1_q <= ext_s1_d;
            ext_s2_q <= ext_s2_d;
        end
    end
`else
    always_comb begin
        hwint_d = {bus.ext_irq, bus.dev1_irq, bus.dev0_irq};
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hwint_q <= 6'd0;
        else       hwint_q <= hwint_d;
    end

    // Strobes and handshake decode straight from registered state so reset drops them at once.
    always_comb begin
        bus.dev0_we   = (state_q == ACCESS) && we_q && sel0_q;
        bus.dev1_we   = (state_q == ACCESS) && we_q && sel1_q;
        bus.cpu_ready = (state_q == RESP) || (state_q == ERR);
        bus.cpu_err   = (state_q == ERR);
        bus.cpu_rd    = cpu_rd_q;
        bus.dev_addr  = dev_addr_q;
        bus.dev_wd    = dev_wd_q;
        bus.HWInt     = hwint_q;
    end

endmodule

// File: tb/tb_dev_bridge.sv
// Randomized self-checking bench for dev_bridge: device register models on the bus,
// and a word-array reference model of both devices that predicts every CPU response.
module tb_dev_bridge;

    localparam logic [31:0] DEV0 = 32'h0000_7F00;
    localparam logic [31:0] DEV1 = 32'h0000_7F10;
`ifdef BRIDGE_IRQ_SYNC_EN
    localparam int EXT_LAT = 3;
`else
    localparam int EXT_LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dev_bridge_if bus();

    dev_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Device register files as the peripherals hold them.
    logic [31:0] mem0 [4];
    logic [31:0] mem1 [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem0[i] <= 32'd0;
                mem1[i] <= 32'd0;
            end
        end else begin
            if (bus.dev0_we) mem0[bus.dev_addr[3:2]] <= bus.dev_wd;
            if (bus.dev1_we) mem1[bus.dev_addr[3:2]] <= bus.dev_wd;
        end
    end

    assign bus.dev0_rd = mem0[bus.dev_addr[3:2]];
    assign bus.dev1_rd = mem1[bus.dev_addr[3:2]];

    // Reference contents, updated only from the bench's own view of accepted writes.
    logic [31:0] ref0 [4];
    logic [31:0] ref1 [4];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 4; i++) begin
            ref0[i] = 32'd0;
            ref1[i] = 32'd0;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rd"},    bus.cpu_rd, 32'd0);
        check({pfx, "_ready"}, 32'(bus.cpu_ready), 32'd0);
        check({pfx, "_err"},   32'(bus.cpu_err), 32'd0);
        check({pfx, "_daddr"}, bus.dev_addr, 32'd0);
        check({pfx, "_dwd"},   bus.dev_wd, 32'd0);
        check({pfx, "_we0"},   32'(bus.dev0_we), 32'd0);
        check({pfx, "_we1"},   32'(bus.dev1_we), 32'd0);
        check({pfx, "_hwint"}, 32'(bus.HWInt), 32'd0);
    endtask

    // One complete CPU access; expectations come from the address map, not from the DUT.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bit          aligned, in0, in1, ok, got;
        int          idx, lat, s0, s1;
        logic [31:0] exp_rd, rd;
        logic        err;
        aligned = (addr % 4) == 0;
        in0     = (addr >= DEV0) && (addr < DEV0 + 32'd16);
        in1     = (addr >= DEV1) && (addr < DEV1 + 32'd16);
        ok      = aligned && (in0 || in1);
        idx     = 0;
        exp_rd  = 32'd0;
        if (ok) begin
            idx = in0 ? int'((addr - DEV0) / 4) : int'((addr - DEV1) / 4);
            if (!we) exp_rd = in0 ? ref0[idx] : ref1[idx];
        end

        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_wd   = wd;
        got = 0; lat = 0; s0 = 0; s1 = 0; rd = 32'd0; err = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.dev0_we || bus.dev1_we) begin
                if (bus.dev0_we) s0++;
                if (bus.dev1_we) s1++;
                check("strobe_addr", bus.dev_addr, addr);
                check("strobe_wd", bus.dev_wd, wd);
            end
            if (bus.cpu_ready) begin
                got = 1;
                rd  = bus.cpu_rd;
                err = bus.cpu_err;
            end
        end
        bus.cpu_req = 1'b0;
        check("ready_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), ok ? 32'd2 : 32'd1);
        check("cpu_err", 32'(err), ok ? 32'd0 : 32'd1);
        check("cpu_rd", rd, exp_rd);
        check("dev0_we_count", 32'(s0), (ok && we && in0) ? 32'd1 : 32'd0);
        check("dev1_we_count", 32'(s1), (ok && we && !in0 && in1) ? 32'd1 : 32'd0);
        if (ok && we) begin
            if (in0) ref0[idx] = wd;
            else     ref1[idx] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_addr(input int kind);
        case (kind)
            0:       return DEV0 + 32'(4 * $urandom_range(0, 3));
            1:       return DEV1 + 32'(4 * $urandom_range(0, 3));
            2:       return DEV0 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            3:       return DEV1 + 32'd16 + 32'(4 * $urandom_range(0, 3));
            4:       return DEV0 - 32'(4 * $urandom_range(1, 4));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] acc_a, acc_w;
        int          nready, nstb;

        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wd   = 32'd0;
        bus.dev0_irq = 1'b0;
        bus.dev1_irq = 1'b0;
        bus.ext_irq  = 4'd0;
        clear_ref();

        reset = 1'b1;
        #1;
        check_all_zero("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed: dev0 write, dev1 write/read-back, error cases.
        do_access(1'b1, 32'h0000_7F00, 32'h0000_0009);
        do_access(1'b1, 32'h0000_7F18, 32'h0000_1234);
        do_access(1'b0, 32'h0000_7F18, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_7F00, 32'd0);
        do_access(1'b0, 32'h0000_7F20, 32'd0);
        do_access(1'b1, 32'h0000_7F02, 32'h5555_AAAA);
        do_access(1'b0, 32'h0000_7F1C, 32'd0);
        do_access(1'b0, 32'h0000_7EFC, 32'd0);

        // Randomized mix of reads, writes, and good/bad addresses.
        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom_range(0, 1)), pick_addr($urandom_range(0, 7) % 6), $urandom());
        end

        // Request held for 9 cycles: one acceptance every third edge, latched values frozen.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = pick_addr(0);
        bus.cpu_wd   = $urandom();
        acc_a = 32'd0; acc_w = 32'd0; nready = 0; nstb = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            if (k % 3 == 0) begin
                acc_a = bus.cpu_addr;
                acc_w = bus.cpu_wd;
                if (acc_a < DEV1) ref0[(acc_a - DEV0) / 4] = acc_w;
                else              ref1[(acc_a - DEV1) / 4] = acc_w;
            end
            #1;
            if (bus.dev0_we || bus.dev1_we) nstb++;
            if (bus.cpu_ready) nready++;
            check("held_dev_addr", bus.dev_addr, acc_a);
            check("held_dev_wd", bus.dev_wd, acc_w);
            bus.cpu_addr = pick_addr($urandom_range(0, 1));
            bus.cpu_wd   = $urandom();
        end
        bus.cpu_req = 1'b0;
        check("held_ready_count", 32'(nready), 32'd3);
        check("held_strobe_count", 32'(nstb), 32'd3);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, DEV0 + 32'(4 * i), 32'd0);
            do_access(1'b0, DEV1 + 32'(4 * i), 32'd0);
        end

        // Interrupt latency.
        @(negedge clk);
        bus.dev0_irq = 1'b1;
        #1;
        check("hwint0_before", 32'(bus.HWInt[0]), 32'd0);
        @(posedge clk);
        #1;
        check("hwint0_after", 32'(bus.HWInt[0]), 32'd1);
        @(negedge clk);
        bus.ext_irq = 4'b0100;
        for (int i = 1; i <= EXT_LAT; i++) begin
            @(posedge clk);
            #1;
            check("hwint4_latency", 32'(bus.HWInt[4]), (i == EXT_LAT) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.dev1_irq = 1'b1;
        do_access(1'b0, DEV1, 32'd0);
        check("hwint_during_access", 32'(bus.HWInt), 32'b010011);
        @(negedge clk);
        bus.dev0_irq = 1'b0;
        @(posedge clk);
        #1;
        check("hwint0_clear", 32'(bus.HWInt[0]), 32'd0);

        // Asynchronous reset in the middle of a write: everything drops at once, no response.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = DEV0 + 32'd4;
        bus.cpu_wd   = 32'hCAFE_0001;
        @(posedge clk);
        #2;
        check("pre_reset_strobe", 32'(bus.dev0_we), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        bus.cpu_req  = 1'b0;
        bus.dev1_irq = 1'b0;
        bus.ext_irq  = 4'd0;
        clear_ref();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nready = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.cpu_ready || bus.dev0_we || bus.dev1_we) nready++;
        end
        check("dropped_access_quiet", 32'(nready), 32'd0);
        do_access(1'b0, DEV0 + 32'd4, 32'd0);
        do_access(1'b1, DEV1 + 32'd8, 32'h0BAD_F00D);
        do_access(1'b0, DEV1 + 32'd8, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
